// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmit FSM phases; IDLE must be the reset encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Word indices local to the device base.
  localparam logic [29:0] REG_TXDATA  = 30'd0;
  localparam logic [29:0] REG_STATUS  = 30'd1;
  localparam logic [29:0] REG_DIVISOR = 30'd2;

  // STATUS register bit positions.
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_EMPTY_BIT = 2;
  localparam int unsigned STATUS_OVF_BIT   = 3;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  // A zero divisor would never end a bit, so it is promoted to one.
  function automatic logic [15:0] div_sanitize(input logic [15:0] val);
    return (val == 16'd0) ? 16'd1 : val;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head entry is readable combinationally before the pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy next state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, bit-timer FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] dev_addr,
  input  logic        dev_re,
  output logic [31:0] dev_rd,
  input  logic        dev_we,
  input  logic [31:0] dev_wd,
  output logic        txd,
  output logic        irq_empty
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    divisor_q, divisor_d;
  logic [15:0]    div_cur_q, div_cur_d;
  logic [15:0]    timer_q, timer_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           ovf_q, ovf_d;
  logic           txd_q, txd_d;

  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           busy;
  logic           wr_status;
  logic           wr_divisor;

  // Reads have no side effects and the upper write bits carry nothing.
  logic unused_ok;
  assign unused_ok = ^{dev_re, dev_wd[31:16]};

  assign fifo_push  = dev_we && (dev_addr == REG_TXDATA);
  assign wr_status  = dev_we && (dev_addr == REG_STATUS);
  assign wr_divisor = dev_we && (dev_addr == REG_DIVISOR);

  assign busy      = (state_q != IDLE);
  assign irq_empty = fifo_empty && !busy;
  assign txd       = txd_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dev_wd[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register file next state: sticky overflow with W1C, sanitised divisor.
  always_comb begin
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && dev_wd[STATUS_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
    if (wr_divisor) divisor_d = div_sanitize(dev_wd[15:0]);
  end

  // Read mux, purely a function of address and current state.
  always_comb begin
    dev_rd = 32'd0;
    case (dev_addr)
      REG_STATUS: begin
        dev_rd[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
        dev_rd[STATUS_OVF_BIT]        = ovf_q;
        dev_rd[STATUS_EMPTY_BIT]      = fifo_empty;
        dev_rd[STATUS_FULL_BIT]       = fifo_full;
        dev_rd[STATUS_BUSY_BIT]       = busy;
      end
      REG_DIVISOR: dev_rd[15:0] = divisor_q;
      default:     dev_rd = 32'd0;
    endcase
  end

  // Frame sequencing; the head byte is popped straight into the shifter when a frame starts.
  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_d   = fifo_head;
          div_cur_d = divisor_q;
          timer_d   = divisor_q - 16'd1;
          bit_cnt_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (timer_q == 16'd0) begin
          timer_d = div_cur_q - 16'd1;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = div_cur_q - 16'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == 16'd0) begin
          if (!fifo_empty) begin
            // Back-to-back: next start bit follows the stop bit with no idle gap.
            fifo_pop  = 1'b1;
            shreg_d   = fifo_head;
            div_cur_d = divisor_q;
            timer_d   = divisor_q - 16'd1;
            bit_cnt_d = 3'd0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state so txd is glitch-free.
  always_comb begin
    txd_d = 1'b1;
    if (state_d == START)     txd_d = 1'b0;
    else if (state_d == DATA) txd_d = shreg_d[0];
  end

  // Control and datapath state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      divisor_q <= DIV_RESET;
      div_cur_q <= DIV_RESET;
      timer_q   <= 16'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'd0;
      ovf_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      div_cur_q <= div_cur_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ovf_q     <= ovf_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] dev_addr = '0;
  logic        dev_re = 1'b0;
  logic [31:0] dev_rd;
  logic        dev_we = 1'b0;
  logic [31:0] dev_wd = '0;
  logic        txd;
  logic        irq_empty;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH (16),
    .DIV_RESET  (16'd868)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_addr  (dev_addr),
    .dev_re    (dev_re),
    .dev_rd    (dev_rd),
    .dev_we    (dev_we),
    .dev_wd    (dev_wd),
    .txd       (txd),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [29:0] addr, input logic [31:0] data);
    dev_addr = addr;
    dev_wd   = data;
    dev_we   = 1'b1;
    tick();
    dev_we   = 1'b0;
  endtask

  task automatic reg_rd(input logic [29:0] addr, output logic [31:0] data);
    dev_addr = addr;
    dev_re   = 1'b1;
    #1;
    data     = dev_rd;
    dev_re   = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of a 10-bit frame at the given divisor.
  // Optionally writes DIVISOR on frame cycle 7 to probe mid-frame updates.
  task automatic run_frame(input string name, input logic [7:0] data, input int unsigned div,
                           input bit mid_wr, input logic [15:0] mid_val,
                           output int unsigned waited);
    logic [9:0]  bits;
    logic        seen;
    logic        bad;
    int unsigned cyc;
    waited = 0;
    while (txd !== 1'b0 && waited < 300) begin
      tick();
      waited++;
    end
    if (txd !== 1'b0) begin
      check_eq({name, "_start_timeout"}, {31'd0, txd}, 32'd0);
      return;
    end
    check_eq({name, "_busy"}, {31'd0, dut.busy}, 32'd1);
    bits = {1'b1, data, 1'b0};
    cyc  = 0;
    for (int b = 0; b < 10; b++) begin
      seen = txd;
      bad  = 1'b0;
      for (int c = 0; c < int'(div); c++) begin
        if (txd !== bits[b]) bad = 1'b1;
        if (mid_wr && cyc == 7) begin
          dev_addr = 30'd2;
          dev_wd   = {16'd0, mid_val};
          dev_we   = 1'b1;
        end
        tick();
        dev_we = 1'b0;
        cyc++;
      end
      check_eq($sformatf("%s_bit%0d", name, b), {30'd0, bad, seen}, {30'd0, 1'b0, bits[b]});
    end
  endtask

  logic [31:0] rdata;
  int unsigned waited;
  int unsigned guard;
  int unsigned lows;

  initial begin
    // 1: reset state
    repeat (3) tick();
    reset = 1'b0;
    reg_rd(30'd1, rdata);
    check_eq("rst_status", rdata, 32'h0000_0004);
    reg_rd(30'd2, rdata);
    check_eq("rst_divisor", rdata, 32'h0000_0364);
    check_eq("rst_txd", {31'd0, txd}, 32'd1);
    check_eq("rst_irq", {31'd0, irq_empty}, 32'd1);
    reg_rd(30'd0, rdata);
    check_eq("txdata_reads_zero", rdata, 32'd0);
    reg_rd(30'd7, rdata);
    check_eq("unmapped_reads_zero", rdata, 32'd0);

    // 2: single frame 0xA5 at DIVISOR=4
    reg_wr(30'd2, 32'd4);
    reg_rd(30'd2, rdata);
    check_eq("div4_readback", rdata, 32'd4);
    reg_wr(30'd0, 32'h0000_00A5);
    run_frame("a5", 8'hA5, 4, 1'b0, 16'd0, waited);
    check_eq("a5_busy_drop", {31'd0, dut.busy}, 32'd0);
    check_eq("a5_irq", {31'd0, irq_empty}, 32'd1);
    check_eq("a5_txd_idle", {31'd0, txd}, 32'd1);

    // 3: overflow. First byte leaves for the shifter one cycle after it lands,
    // so 17 back-to-back pushes fill the FIFO and the next push is dropped.
    reg_wr(30'd2, 32'd2);
    for (int i = 0; i < 17; i++) reg_wr(30'd0, 32'(i + 8'h10));
    reg_rd(30'd1, rdata);
    check_eq("fill_status", rdata, 32'h0000_1003);
    reg_wr(30'd0, 32'h0000_00EE);
    reg_rd(30'd1, rdata);
    check_eq("ovf_status", rdata, 32'h0000_100B);
    reg_wr(30'd1, 32'h0000_0008);
    reg_rd(30'd1, rdata);
    check_eq("ovf_clear", rdata, 32'h0000_1003);
    guard = 0;
    while (irq_empty !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    check_eq("drain_irq", {31'd0, irq_empty}, 32'd1);
    reg_rd(30'd1, rdata);
    check_eq("drain_status", rdata, 32'h0000_0004);

    // 4: back-to-back frames at DIVISOR=3
    reg_wr(30'd2, 32'd3);
    reg_wr(30'd0, 32'h0000_0001);
    reg_wr(30'd0, 32'h0000_0080);
    run_frame("b01", 8'h01, 3, 1'b0, 16'd0, waited);
    run_frame("b80", 8'h80, 3, 1'b0, 16'd0, waited);
    check_eq("b2b_no_gap", waited, 32'd0);
    check_eq("b2b_idle", {31'd0, dut.busy}, 32'd0);

    // 5: divisor sanitising and mid-frame update
    reg_wr(30'd2, 32'd0);
    reg_rd(30'd2, rdata);
    check_eq("div0_to_1", rdata, 32'd1);
    reg_wr(30'd2, 32'hABCD_0005);
    reg_rd(30'd2, rdata);
    check_eq("div_upper_zero", rdata, 32'd5);
    reg_wr(30'd0, 32'h0000_003C);
    reg_wr(30'd0, 32'h0000_00C3);
    run_frame("m3c", 8'h3C, 5, 1'b1, 16'd8, waited);
    run_frame("mc3", 8'hC3, 8, 1'b0, 16'd0, waited);
    check_eq("mid_no_gap", waited, 32'd0);
    check_eq("mid_idle", {31'd0, dut.busy}, 32'd0);
    reg_rd(30'd2, rdata);
    check_eq("mid_div8", rdata, 32'd8);

    // 6: reset mid-frame with 3 bytes queued
    reg_wr(30'd2, 32'd4);
    for (int i = 0; i < 4; i++) reg_wr(30'd0, 32'h0000_0055);
    guard = 0;
    while (txd !== 1'b0 && guard < 50) begin
      tick();
      guard++;
    end
    repeat (20) tick();
    reg_rd(30'd1, rdata);
    check_eq("pre_rst_status", rdata, 32'h0000_0301);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_txd", {31'd0, txd}, 32'd1);
    reg_rd(30'd1, rdata);
    check_eq("mid_rst_status", rdata, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1 || dut.busy !== 1'b0) lows++;
      tick();
    end
    check_eq("no_frame_after_rst", lows, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
